// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER memory arbiter: FSM states, access owner,
// and the fixed access size used for instruction fetches.
package otter_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_CMD  = 2'b01,
        ARB_WAIT = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam int         STARVE_CNT_W = 4;

endpackage

// File: rtl/otter_mem_arb_prio.sv
// Winner selection between fetch and data requests. Data wins by default; a saturating
// counter of contested data wins hands the next contested slot to fetch.
module otter_mem_arb_prio
    import otter_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic win_if,
    output logic win_d
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_r;
    logic                    starved_s;

    // Combinational winner select
    always_comb begin
        starved_s = (starve_cnt_r == LIMIT);
        win_d     = d_req && !(if_req && starved_s);
        win_if    = if_req && !win_d;
    end

    // Starve counter: counts contested data wins, cleared by any fetch grant
    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt_r <= '0;
        end else if (grant_en && win_if) begin
            starve_cnt_r <= '0;
        end else if (grant_en && win_d && if_req && (starve_cnt_r != LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + STARVE_CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares a single-ported, 1-cycle-latency memory between instruction fetch and the data port.
// IDLE registers one request, CMD strobes memory, WAIT captures read data for the owner.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_ACK,
    output logic [31:0] IF_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    input  logic        D_SIGN,
    output logic        D_ACK,
    output logic [31:0] D_RDATA,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_DIN,
    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT,
    output logic        BUSY
);

    arb_state_t state_r;
    arb_state_t state_nx_s;
    arb_owner_t owner_r;
    logic       mem_re_r;
    logic       mem_we_r;
    logic       if_req_s;
    logic       d_req_s;
    logic       grant_s;
    logic       win_if_s;
    logic       win_d_s;

    // A port's request is ignored during its own ACK cycle so a held REQ does not reissue
    assign if_req_s = IF_REQ && !IF_ACK;
    assign d_req_s  = D_REQ && !D_ACK;
    assign grant_s  = (state_r == ARB_IDLE) && (if_req_s || d_req_s);

    // Strobes are gated by RESET so a store caught in CMD never reaches memory
    assign MEM_RE = mem_re_r && !RESET;
    assign MEM_WE = mem_we_r && !RESET;
    assign BUSY   = (state_r != ARB_IDLE);

    otter_mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .CLK      (CLK),
        .RESET    (RESET),
        .if_req   (if_req_s),
        .d_req    (d_req_s),
        .grant_en (grant_s),
        .win_if   (win_if_s),
        .win_d    (win_d_s)
    );

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (grant_s) begin
                    state_nx_s = ARB_CMD;
                end else begin
                    state_nx_s = ARB_IDLE;
                end
            end
            ARB_CMD: begin
                if (mem_we_r) begin
                    state_nx_s = ARB_IDLE;
                end else begin
                    state_nx_s = ARB_WAIT;
                end
            end
            ARB_WAIT: state_nx_s = ARB_IDLE;
            default:  state_nx_s = ARB_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Request capture, memory strobes, read-data return and ACK pulses
    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_r  <= OWN_IF;
            mem_re_r <= 1'b0;
            mem_we_r <= 1'b0;
            IF_ACK   <= 1'b0;
            D_ACK    <= 1'b0;
            IF_RDATA <= 32'h0000_0000;
            D_RDATA  <= 32'h0000_0000;
            MEM_ADDR <= 32'h0000_0000;
            MEM_DIN  <= 32'h0000_0000;
            MEM_SIZE <= 2'b00;
            MEM_SIGN <= 1'b0;
        end else begin
            mem_re_r <= 1'b0;
            mem_we_r <= 1'b0;
            IF_ACK   <= 1'b0;
            D_ACK    <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (grant_s && win_d_s) begin
                        owner_r  <= OWN_D;
                        MEM_ADDR <= D_ADDR;
                        MEM_DIN  <= D_WDATA;
                        MEM_SIZE <= D_SIZE;
                        MEM_SIGN <= D_SIGN;
                        mem_we_r <= D_WE;
                        mem_re_r <= !D_WE;
                    end else if (grant_s && win_if_s) begin
                        owner_r  <= OWN_IF;
                        MEM_ADDR <= IF_ADDR;
                        MEM_SIZE <= SIZE_WORD;
                        MEM_SIGN <= 1'b0;
                        mem_re_r <= 1'b1;
                    end
                end
                ARB_CMD: begin
                    D_ACK <= mem_we_r;
                end
                ARB_WAIT: begin
                    if (owner_r == OWN_D) begin
                        D_RDATA <= MEM_DOUT;
                        D_ACK   <= 1'b1;
                    end else begin
                        IF_RDATA <= MEM_DOUT;
                        IF_ACK   <= 1'b1;
                    end
                end
                default: begin
                    owner_r <= owner_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed self-checking bench for otter_mem_arbiter with a behavioural 1-cycle-latency
// memory that performs the size/sign extension on reads.
module tb_otter_mem_arbiter;

    logic        CLK;
    logic        RESET;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_ACK;
    logic [31:0] IF_RDATA;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [1:0]  D_SIZE;
    logic        D_SIGN;
    logic        D_ACK;
    logic [31:0] D_RDATA;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_DIN;
    logic        MEM_RE;
    logic        MEM_WE;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT;
    logic        BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:4095];

    otter_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_SIZE(D_SIZE), .D_SIGN(D_SIGN), .D_ACK(D_ACK), .D_RDATA(D_RDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT(MEM_DOUT), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory read extension: D_SIGN/MEM_SIGN = 1 means zero-extend
    function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] bo,
                                           input logic [1:0] sz, input logic sg);
        logic [31:0] sh;
        sh = w >> {bo, 3'b000};
        case (sz)
            2'b00:   return sg ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return sg ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (MEM_WE === 1'b1) mem[12'(MEM_ADDR >> 2)] <= MEM_DIN;
        if (MEM_RE === 1'b1)
            MEM_DOUT <= rd_ext(mem[12'(MEM_ADDR >> 2)], MEM_ADDR[1:0], MEM_SIZE, MEM_SIGN);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge CLK);
    endtask

    // Full word store transaction with fixed timing; starts and ends idle at a negedge
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = addr; D_WDATA = data; D_SIZE = 2'b10; D_SIGN = 1'b0;
        step(); step();
        D_REQ = 1'b0;
        step();
    endtask

    // Full load transaction with fixed timing; returns D_RDATA seen in the ACK cycle
    task automatic do_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                           output logic [31:0] data);
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = addr; D_SIZE = sz; D_SIGN = sg;
        step(); step(); step();
        data = D_RDATA;
        D_REQ = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step(); step();
        n_checks++;
        if ({IF_ACK, D_ACK, MEM_RE, MEM_WE, BUSY} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: {IF_ACK,D_ACK,MEM_RE,MEM_WE,BUSY}=%b required 00000",
                     {IF_ACK, D_ACK, MEM_RE, MEM_WE, BUSY});
        end
        n_checks++;
        if ({IF_RDATA, D_RDATA, MEM_ADDR, MEM_DIN} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: IF_RDATA=%h D_RDATA=%h MEM_ADDR=%h MEM_DIN=%h required all 0",
                     IF_RDATA, D_RDATA, MEM_ADDR, MEM_DIN);
        end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_lone_fetch();
        do_store(32'h0000_0100, 32'h0050_0093);
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0100;
        step();
        IF_ADDR = 32'hFFFF_FFFC;
        n_checks++;
        if ({MEM_RE, MEM_WE, BUSY, MEM_SIZE, MEM_SIGN} !== 6'b101100 || MEM_ADDR !== 32'h100) begin
            n_fail++;
            $display("FAIL fetch_cmd: RE=%b WE=%b BUSY=%b SIZE=%b SIGN=%b ADDR=%h required 1 0 1 10 0 00000100",
                     MEM_RE, MEM_WE, BUSY, MEM_SIZE, MEM_SIGN, MEM_ADDR);
        end
        n_checks++;
        if (MEM_DIN !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL fetch_din_hold: MEM_DIN=%h required 00500093", MEM_DIN);
        end
        step();
        n_checks++;
        if ({MEM_RE, BUSY, IF_ACK} !== 3'b010) begin
            n_fail++;
            $display("FAIL fetch_wait: RE=%b BUSY=%b IF_ACK=%b required 0 1 0", MEM_RE, BUSY, IF_ACK);
        end
        step();
        n_checks++;
        if ({IF_ACK, D_ACK, BUSY} !== 3'b100 || IF_RDATA !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL fetch_ack: IF_ACK=%b D_ACK=%b BUSY=%b IF_RDATA=%h required 1 0 0 00500093",
                     IF_ACK, D_ACK, BUSY, IF_RDATA);
        end
        IF_REQ = 1'b0;
        step();
        n_checks++;
        if (IF_ACK !== 1'b0 || IF_RDATA !== 32'h0050_0093 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_after: IF_ACK=%b IF_RDATA=%h BUSY=%b required 0 00500093 0",
                     IF_ACK, IF_RDATA, BUSY);
        end
    endtask

    task automatic test_lone_store();
        logic [31:0] rd;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h0000_2000; D_WDATA = 32'hDEAD_BEEF;
        D_SIZE = 2'b10; D_SIGN = 1'b0;
        step();
        D_WDATA = 32'h0000_0000;
        n_checks++;
        if ({MEM_WE, MEM_RE, BUSY} !== 3'b101 || MEM_ADDR !== 32'h2000 || MEM_DIN !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_cmd: WE=%b RE=%b BUSY=%b ADDR=%h DIN=%h required 1 0 1 00002000 deadbeef",
                     MEM_WE, MEM_RE, BUSY, MEM_ADDR, MEM_DIN);
        end
        step();
        n_checks++;
        if ({MEM_WE, D_ACK, BUSY} !== 3'b010) begin
            n_fail++;
            $display("FAIL store_ack: WE=%b D_ACK=%b BUSY=%b required 0 1 0", MEM_WE, D_ACK, BUSY);
        end
        D_REQ = 1'b0;
        step();
        n_checks++;
        if (D_ACK !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ack_pulse: D_ACK=%b required 0", D_ACK);
        end
        do_load(32'h0000_2000, 2'b10, 1'b0, rd);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_readback: D_RDATA=%h required deadbeef", rd);
        end
    endtask

    task automatic test_byte_load();
        logic [31:0] rd;
        do_store(32'h0000_2000, 32'h0000_00F0);
        for (int s = 0; s < 2; s++) begin
            D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_2000; D_SIZE = 2'b00; D_SIGN = s[0];
            step();
            n_checks++;
            if (MEM_SIZE !== 2'b00 || MEM_SIGN !== s[0] || MEM_RE !== 1'b1) begin
                n_fail++;
                $display("FAIL byte_cmd_s%0d: SIZE=%b SIGN=%b RE=%b required 00 %0d 1",
                         s, MEM_SIZE, MEM_SIGN, MEM_RE, s);
            end
            step(); step();
            rd = (s == 0) ? 32'hFFFF_FFF0 : 32'h0000_00F0;
            n_checks++;
            if (D_ACK !== 1'b1 || D_RDATA !== rd) begin
                n_fail++;
                $display("FAIL byte_data_s%0d: D_ACK=%b D_RDATA=%h required 1 %h", s, D_ACK, D_RDATA, rd);
            end
            D_REQ = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        do_store(32'h0000_2000, 32'h1111_1111);
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h0000_2000; D_WDATA = 32'hCAFE_F00D; D_SIZE = 2'b10;
        step();
        RESET = 1'b1;
        D_REQ = 1'b0;
        #1;
        n_checks++;
        if (MEM_WE !== 1'b0 || MEM_RE !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_cmd_strobe: MEM_WE=%b MEM_RE=%b required 0 0", MEM_WE, MEM_RE);
        end
        step();
        n_checks++;
        if ({D_ACK, IF_ACK, BUSY, MEM_WE, MEM_RE} !== 5'b00000 ||
            {MEM_ADDR, MEM_DIN, D_RDATA, IF_RDATA} !== 128'h0) begin
            n_fail++;
            $display("FAIL rst_outputs: D_ACK=%b IF_ACK=%b BUSY=%b ADDR=%h DIN=%h D_RDATA=%h required zeros",
                     D_ACK, IF_ACK, BUSY, MEM_ADDR, MEM_DIN, D_RDATA);
        end
        RESET = 1'b0;
        step();
        n_checks++;
        if (D_ACK !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_ack: D_ACK=%b BUSY=%b required 0 0", D_ACK, BUSY);
        end
        do_load(32'h0000_2000, 2'b10, 1'b0, rd);
        n_checks++;
        if (rd !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL rst_mem_kept: mem[2000]=%h required 11111111", rd);
        end
    endtask

    task automatic test_back_to_back();
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h0000_3000; D_WDATA = 32'h1234_5678; D_SIZE = 2'b10;
        step();
        step();
        n_checks++;
        if (D_ACK !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_first_ack: D_ACK=%b required 1", D_ACK);
        end
        step();
        n_checks++;
        if (BUSY !== 1'b0 || MEM_WE !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_dup: BUSY=%b MEM_WE=%b required 0 0", BUSY, MEM_WE);
        end
        step();
        n_checks++;
        if (MEM_WE !== 1'b1 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_reissue: MEM_WE=%b BUSY=%b required 1 1", MEM_WE, BUSY);
        end
        D_REQ = 1'b0;
        step();
        n_checks++;
        if (D_ACK !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_second_ack: D_ACK=%b required 1", D_ACK);
        end
        step();
        n_checks++;
        if ({BUSY, D_ACK, MEM_WE} !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_settle: BUSY=%b D_ACK=%b MEM_WE=%b required 0 0 0", BUSY, D_ACK, MEM_WE);
        end
    endtask

    // Both ports held high: the owner is masked in its ACK cycle, so grants alternate D, IF, D, ...
    task automatic test_contention();
        int g;
        g = 0;
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0100;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h0000_3000; D_WDATA = 32'h5A5A_5A5A; D_SIZE = 2'b10;
        for (int c = 0; c < 40; c++) begin
            step();
            n_checks++;
            if (IF_ACK === 1'b1 && D_ACK === 1'b1) begin
                n_fail++;
                $display("FAIL cont_double_ack: cycle %0d IF_ACK=1 D_ACK=1 required at most one", c);
            end
            if ((MEM_WE === 1'b1 || MEM_RE === 1'b1) && g < 6) begin
                n_checks++;
                if ((MEM_ADDR === 32'h3000) !== (g % 2 == 0)) begin
                    n_fail++;
                    $display("FAIL cont_grant_%0d: MEM_ADDR=%h required %s", g, MEM_ADDR,
                             (g % 2 == 0) ? "D 00003000" : "IF 00000100");
                end
                g++;
                if (g == 6) begin
                    IF_REQ = 1'b0;
                    D_REQ = 1'b0;
                end
            end
        end
        n_checks++;
        if (g != 6) begin
            n_fail++;
            $display("FAIL cont_grant_count: grants=%0d required 6", g);
        end
    endtask

    // IF pulses its request only in contested slots: four D wins, then IF must win the fifth
    task automatic test_starvation();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        step();
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 5; r++) begin
                IF_REQ = 1'b1; IF_ADDR = 32'h0000_0100;
                D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h0000_3000; D_WDATA = 32'(r); D_SIZE = 2'b10;
                step();
                if (r < 4) begin
                    n_checks++;
                    if (MEM_WE !== 1'b1 || MEM_ADDR !== 32'h3000) begin
                        n_fail++;
                        $display("FAIL starve_b%0d_r%0d: WE=%b RE=%b ADDR=%h required D store to 00003000",
                                 b, r, MEM_WE, MEM_RE, MEM_ADDR);
                    end
                    IF_REQ = 1'b0;
                    step();
                    D_REQ = 1'b0;
                    step();
                end else begin
                    n_checks++;
                    if (MEM_RE !== 1'b1 || MEM_ADDR !== 32'h100) begin
                        n_fail++;
                        $display("FAIL starve_b%0d_if_win: RE=%b WE=%b ADDR=%h required IF fetch of 00000100",
                                 b, MEM_RE, MEM_WE, MEM_ADDR);
                    end
                    step(); step();
                    n_checks++;
                    if (IF_ACK !== 1'b1 || D_ACK !== 1'b0) begin
                        n_fail++;
                        $display("FAIL starve_b%0d_if_ack: IF_ACK=%b D_ACK=%b required 1 0", b, IF_ACK, D_ACK);
                    end
                    IF_REQ = 1'b0;
                    step();
                    n_checks++;
                    if (MEM_WE !== 1'b1 || MEM_ADDR !== 32'h3000) begin
                        n_fail++;
                        $display("FAIL starve_b%0d_d_after: WE=%b ADDR=%h required D store to 00003000",
                                 b, MEM_WE, MEM_ADDR);
                    end
                    step();
                    D_REQ = 1'b0;
                    step();
                end
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        IF_REQ = 1'b0; IF_ADDR = 32'h0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 32'h0; D_WDATA = 32'h0; D_SIZE = 2'b00; D_SIGN = 1'b0;
        test_reset();
        test_lone_fetch();
        test_lone_store();
        test_byte_load();
        test_reset_mid();
        test_back_to_back();
        test_contention();
        test_starvation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
